button_input_debouncer: RTL and testbench

Input-side companion to the board LED outputs: conditions raw mechanical push-buttons into clean, single-clock-domain levels and one-cycle events. Each button is synchronised, debounced, and edge-detected. The block sits between the top-level pads and the counter or SoC logic, so user input can drive the design that the LEDs display.

---
 rtl/button_pkg.sv | 19 +
 rtl/button_channel.sv | 134 +++++++++++++
 rtl/button_input_debouncer.sv | 40 ++++
 tb/tb_button_input_debouncer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and sizing helpers for the push-button debouncer.
// Optional long-press detection is enabled with BUTTON_LONG_PRESS_EN.
package button_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESSED,
        HELD
    } btn_state_t;

    localparam int DEF_DEBOUNCE_CYCLES   = 500000;
    localparam int DEF_LONG_PRESS_CYCLES = 50000000;

    // Width of a counter that must reach n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button lane: 2-FF synchroniser, debounce, press/release/hold events.
// Hold counter and HELD state exist only with BUTTON_LONG_PRESS_EN.
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    parameter bit ACTIVE_LOW        = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic hold_pulse
);

    localparam int             DW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0]  DMAX = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic           IDLE = ACTIVE_LOW;

    if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES < 1) begin : g_bad_cfg
        $error("button_channel: DEBOUNCE_CYCLES>=2, LONG_PRESS_CYCLES>=1");
    end

    logic          sync1;
    logic          sync2;
    logic          sample;
    logic          stable;
    logic          differ;
    logic          done;
    logic [DW-1:0] dcnt;
    btn_state_t    state;
    btn_state_t    state_d;
    logic          press_d;
    logic          release_d;
    logic          hold_d;

`ifdef BUTTON_LONG_PRESS_EN
    localparam int            HW   = cnt_width(LONG_PRESS_CYCLES);
    localparam logic [HW-1:0] HMAX = HW'(LONG_PRESS_CYCLES - 1);
    logic [HW-1:0] hcnt;
    logic [HW-1:0] hcnt_d;
`endif

    // Synchroniser idles at the released pad level so reset looks unpressed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= IDLE;
            sync2 <= IDLE;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    assign sample = sync2 ^ ACTIVE_LOW;
    assign differ = (sample != stable);
    assign done   = differ && (dcnt == DMAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= 1'b0;
            dcnt   <= '0;
        end else if (!differ) begin
            dcnt   <= '0;
        end else if (done) begin
            stable <= ~stable;
            dcnt   <= '0;
        end else begin
            dcnt   <= dcnt + 1'b1;
        end
    end

    always_comb begin
        state_d   = state;
        press_d   = done && !stable;
        release_d = done && stable;
        hold_d    = 1'b0;
`ifdef BUTTON_LONG_PRESS_EN
        hcnt_d    = hcnt;
`endif
        unique case (state)
            RELEASED: begin
                if (press_d) state_d = PRESSED;
`ifdef BUTTON_LONG_PRESS_EN
                hcnt_d = '0;
`endif
            end
            PRESSED: begin
                if (release_d) begin
                    state_d = RELEASED;
                end
`ifdef BUTTON_LONG_PRESS_EN
                else if (hcnt == HMAX) begin
                    state_d = HELD;
                    hold_d  = 1'b1;
                end else begin
                    hcnt_d  = hcnt + 1'b1;
                end
`endif
            end
            HELD: begin
                if (release_d) state_d = RELEASED;
            end
            default: state_d = RELEASED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RELEASED;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            hold_pulse    <= 1'b0;
        end else begin
            state         <= state_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
            hold_pulse    <= hold_d;
        end
    end

`ifdef BUTTON_LONG_PRESS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hcnt <= '0;
        else        hcnt <= hcnt_d;
    end
`endif

    assign pressed = stable;

endmodule

// File: rtl/button_input_debouncer.sv
// Multi-channel push-button conditioner: level, press/release/hold strobes.
// Long-press detection is compiled in with BUTTON_LONG_PRESS_EN.
module button_input_debouncer
    import button_pkg::*;
#(
    parameter int NUM_BUTTONS       = 4,
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    parameter bit BUTTON_ACTIVE_LOW = 1'b1
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [NUM_BUTTONS-1:0] Buttons,
    output logic [NUM_BUTTONS-1:0] Pressed,
    output logic [NUM_BUTTONS-1:0] PressPulse,
    output logic [NUM_BUTTONS-1:0] ReleasePulse,
    output logic [NUM_BUTTONS-1:0] HoldPulse,
    output logic                   AnyPressed
);

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
            .ACTIVE_LOW       (BUTTON_ACTIVE_LOW)
        ) u_ch (
            .clk          (Clock),
            .rst_n        (Reset),
            .raw          (Buttons[i]),
            .pressed      (Pressed[i]),
            .press_pulse  (PressPulse[i]),
            .release_pulse(ReleasePulse[i]),
            .hold_pulse   (HoldPulse[i])
        );
    end

    // OR of registered levels only, so no path from the pads.
    assign AnyPressed = |Pressed;

endmodule

// File: tb/tb_button_input_debouncer.sv
// Bench for button_input_debouncer: window-based reference model plus
// directed scenarios with literal expectations.
module tb_button_input_debouncer;

    localparam int D = 4;
    localparam int L = 10;
`ifdef BUTTON_LONG_PRESS_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] Buttons = 4'hF;
    logic [3:0] Pressed;
    logic [3:0] PressPulse;
    logic [3:0] ReleasePulse;
    logic [3:0] HoldPulse;
    logic       AnyPressed;

    int checks = 0;
    int errors = 0;

    button_input_debouncer #(
        .NUM_BUTTONS      (4),
        .DEBOUNCE_CYCLES  (D),
        .LONG_PRESS_CYCLES(L),
        .BUTTON_ACTIVE_LOW(1'b1)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Buttons     (Buttons),
        .Pressed     (Pressed),
        .PressPulse  (PressPulse),
        .ReleasePulse(ReleasePulse),
        .HoldPulse   (HoldPulse),
        .AnyPressed  (AnyPressed)
    );

    initial forever #5 Clock = ~Clock;

    task automatic chk(input string nm, input logic [3:0] got,
                       input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b want %b at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    // Reference model: a level is accepted once the last D synchronised
    // samples all disagree with the current level.
    logic [3:0]   s1 = 4'hF;
    logic [3:0]   s2 = 4'hF;
    logic [3:0]   m_samp;
    logic [3:0]   m_stable = '0;
    logic [3:0]   m_pp = '0;
    logic [3:0]   m_rp = '0;
    logic [3:0]   m_hp = '0;
    logic [3:0]   m_held = '0;
    logic [D-1:0] win [4];
    int           cyc = 0;
    int           press_cyc [4];

    initial begin
        for (int c = 0; c < 4; c++) begin
            win[c] = '0;
            press_cyc[c] = 0;
        end
        forever begin
            @(posedge Clock or negedge Reset);
            if (!Reset) begin
                s1 = 4'hF;
                s2 = 4'hF;
                m_stable = '0;
                m_pp = '0;
                m_rp = '0;
                m_hp = '0;
                m_held = '0;
                for (int c = 0; c < 4; c++) win[c] = '0;
            end else begin
                cyc++;
                m_samp = ~s2;
                s2 = s1;
                s1 = Buttons;
                m_pp = '0;
                m_rp = '0;
                m_hp = '0;
                for (int c = 0; c < 4; c++) begin
                    win[c] = {win[c][D-2:0], m_samp[c]};
                    if (win[c] == {D{~m_stable[c]}}) begin
                        m_stable[c] = ~m_stable[c];
                        if (m_stable[c]) begin
                            m_pp[c] = 1'b1;
                            press_cyc[c] = cyc;
                            m_held[c] = 1'b0;
                        end else begin
                            m_rp[c] = 1'b1;
                        end
                    end else if (HOLD_EN && m_stable[c] && !m_held[c]
                                 && (cyc - press_cyc[c] == L)) begin
                        m_hp[c] = 1'b1;
                        m_held[c] = 1'b1;
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge Clock);
        chk("cmp_pressed", Pressed, m_stable);
        chk("cmp_press_pulse", PressPulse, m_pp);
        chk("cmp_release_pulse", ReleasePulse, m_rp);
        chk("cmp_hold_pulse", HoldPulse, m_hp);
        chk("cmp_any", {3'b0, AnyPressed}, {3'b0, |m_stable});
    end

    initial begin
        #1 Reset = 1'b0;
        Buttons = 4'b0000;
        tick(3);
        chk("rst_pressed", Pressed, 4'b0000);
        chk("rst_pulses", PressPulse | ReleasePulse | HoldPulse, 4'b0000);
        chk("rst_any", {3'b0, AnyPressed}, 4'b0000);
        Buttons = 4'b1111;
        tick(1);
        Reset = 1'b1;
        tick(20);
        chk("idle_pressed", Pressed, 4'b0000);
        chk("idle_any", {3'b0, AnyPressed}, 4'b0000);

        // clean press on channel 0
        Buttons[0] = 1'b0;
        tick(5);
        chk("press_e5_level", Pressed, 4'b0000);
        chk("press_e5_pulse", PressPulse, 4'b0000);
        tick(1);
        chk("press_e6_level", Pressed, 4'b0001);
        chk("press_e6_pulse", PressPulse, 4'b0001);
        chk("press_e6_any", {3'b0, AnyPressed}, 4'b0001);
        tick(1);
        chk("press_e7_pulse", PressPulse, 4'b0000);
        Buttons[0] = 1'b1;
        tick(6);
        chk("rel0_pulse", ReleasePulse, 4'b0001);
        chk("rel0_level", Pressed, 4'b0000);
        tick(4);

        // bounce on channel 1: runs of three never reach four
        repeat (3) begin
            Buttons[1] = 1'b0;
            tick(3);
            Buttons[1] = 1'b1;
            tick(1);
            chk("bounce_level", Pressed, 4'b0000);
        end
        Buttons[1] = 1'b0;
        tick(5);
        chk("bounce_e5_pulse", PressPulse, 4'b0000);
        tick(1);
        chk("bounce_e6_pulse", PressPulse, 4'b0010);
        Buttons[1] = 1'b1;
        tick(10);

        // long press on channel 2
        Buttons[2] = 1'b0;
        tick(6);
        chk("long_press_pulse", PressPulse, 4'b0100);
        tick(9);
        chk("long_e15_hold", HoldPulse, 4'b0000);
        tick(1);
        chk("long_e16_hold", HoldPulse, HOLD_EN ? 4'b0100 : 4'b0000);
        tick(1);
        chk("long_e17_hold", HoldPulse, 4'b0000);
        tick(20);
        Buttons[2] = 1'b1;
        tick(6);
        chk("long_rel_pulse", ReleasePulse, 4'b0100);
        chk("long_rel_hold", HoldPulse, 4'b0000);
        tick(4);

        // simultaneous press, then reset during release debounce
        Buttons = 4'b0000;
        tick(6);
        chk("sim_press_pulse", PressPulse, 4'b1111);
        chk("sim_level", Pressed, 4'b1111);
        tick(3);
        Buttons = 4'b1111;
        tick(3);
        Reset = 1'b0;
        #1;
        chk("abort_level", Pressed, 4'b0000);
        chk("abort_any", {3'b0, AnyPressed}, 4'b0000);
        chk("abort_pulses", PressPulse | ReleasePulse | HoldPulse, 4'b0000);
        tick(2);
        Reset = 1'b1;
        tick(10);
        chk("post_abort_level", Pressed, 4'b0000);
        chk("post_abort_rel", ReleasePulse, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
